jk_excitation_driver: RTL
=========================

Name: jk_excitation_driver

Overview:
- Drives the other side of our JK latch interface: takes a stream of desired latch states and generates the J/K excitation needed to reach each one, inverting the JK characteristic table.
- Buffers requested states in a small FIFO, drives J/K for one cycle per request, then waits a settle window and checks the latch output fed back from the DUT.
- Used as a reusable stimulus/checker engine in front of N parallel jk_latch instances.

Parameters:
- N, 4, number of latch bits driven in parallel.
- DEPTH, 4, target FIFO depth in entries; power of two, minimum 2.
- SETTLE_CYC, 2, cycles J=K=0 is held after a drive before the check; minimum 1.
- TOGGLE_EN, 0, 1 = use J=K=1 (toggle) for bits that must change; 0 = use set (10) or reset (01).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- target_valid  input  1  a requested state is presented.
- target  input  N  requested latch state.
- target_ready  output  1  FIFO can accept; equals !full.
- j  output  N  J excitation to the latches.
- k  output  N  K excitation to the latches.
- q_fb  input  N  latch outputs fed back from the DUT.
- q_model  output  N  expected latch state after the last drive.
- check_pulse  output  1  high for exactly the CHECK cycle.
- mismatch  output  1  high in the CHECK cycle when q_fb != q_model.
- err  output  1  sticky mismatch flag.
- err_count  output  8  mismatch count, saturates at 8'hFF.
- busy  output  1  FSM is not in IDLE or FIFO is non-empty.

Behaviour:
- Reset (sync, active-high, has priority over everything):
  - FIFO emptied; state = IDLE.
  - j = k = 0; q_model = 0 (latch reset value).
  - check_pulse = mismatch = err = 0; err_count = 0; busy = 0; target_ready = 1.
  - Reset asserted mid-drive or mid-settle abandons the entry in progress; no check occurs.
- FIFO:
  - Push on target_valid && target_ready.
  - target_ready depends on full only, so it is low whenever the FIFO is full, even in a cycle where a pop occurs.
  - Pop happens only on the IDLE->DRIVE transition. Simultaneous push and pop is legal when not full, and occupancy is unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, DRIVE, SETTLE, CHECK.
  - IDLE: j = k = 0. If the FIFO is non-empty, pop the head, register j/k and the new q_model, then go to DRIVE.
  - DRIVE (1 cycle): registered j/k are presented. Next state is SETTLE with the settle counter loaded to SETTLE_CYC-1.
  - SETTLE: j = k = 0 (hold). Counter decrements each cycle; go to CHECK when it reaches 0. SETTLE therefore lasts SETTLE_CYC cycles.
  - CHECK (1 cycle): check_pulse = 1 and mismatch = (q_fb != q_model), both registered outputs. Next state is IDLE.
- Excitation per bit, with cur = q_model[i] and tgt = target[i]:
  - tgt == cur: j = 0, k = 0.
  - 0 -> 1: TOGGLE_EN = 0 gives j = 1, k = 0; TOGGLE_EN = 1 gives j = 1, k = 1.
  - 1 -> 0: TOGGLE_EN = 0 gives j = 0, k = 1; TOGGLE_EN = 1 gives j = 1, k = 1.
  - q_model <= target on the IDLE->DRIVE edge.
- Latency and throughput:
  - An entry pushed into an empty FIFO at edge t, with the FSM in IDLE, shows j/k at edge t+1 for one cycle.
  - check_pulse follows at edge t+2+SETTLE_CYC.
  - One entry per 3+SETTLE_CYC cycles.
- Error tracking:
  - In the CHECK cycle, a mismatch sets err and increments err_count.
  - err_count holds at 8'hFF once it saturates.
  - err clears only on reset.

Test Plan:
- Reset, then push target=4'b1010 (N=4, TOGGLE_EN=0) with q_fb tracking an ideal latch:
  - j=1010, k=0000 one cycle after the push.
  - check_pulse at push+4 (SETTLE_CYC=2); mismatch=0; q_model=1010.
- Next push target=4'b0110:
  - j=0100, k=1000 (bit3 reset, bit2 set, others hold).
  - Repeat with TOGGLE_EN=1: j=k=1100.
- Push 5 entries back-to-back while DEPTH=4:
  - target_ready drops after the FSM pops the first entry and the FIFO refills to 4.
  - All 5 entries are driven in order; none is lost or duplicated.
- Force q_fb=4'b0000 when q_model=0110:
  - mismatch=1 and err=1 in the CHECK cycle; err_count=1.
  - err stays 1 through subsequent matching checks.
  - 300 forced mismatches leave err_count=8'hFF.
- Assert reset during the SETTLE cycle:
  - Next cycle j=k=0, q_model=0, FIFO empty, no check_pulse, err=0, err_count=0, target_ready=1.
- Identical target pushed twice:
  - The second drive gives j=k=0000 and the check passes.
  - busy stays high from the first push until the second CHECK completes.

Source files
------------

// File: rtl/jk_excitation_driver.sv
// JK excitation driver: buffers requested latch states, derives J/K
// from the inverted JK table, then settles and checks the feedback.
module jk_excitation_driver #(
  parameter int N          = 4,
  parameter int DEPTH      = 4,
  parameter int SETTLE_CYC = 2,
  parameter int TOGGLE_EN  = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         target_valid,
  input  logic [N-1:0] target,
  output logic         target_ready,
  output logic [N-1:0] j,
  output logic [N-1:0] k,
  input  logic [N-1:0] q_fb,
  output logic [N-1:0] q_model,
  output logic         check_pulse,
  output logic         mismatch,
  output logic         err,
  output logic [7:0]   err_count,
  output logic         busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_CHECK
  } state_t;

  state_t         r_state;
  logic [N-1:0]   r_mem [DEPTH];
  logic [AW-1:0]  r_wr;
  logic [AW-1:0]  r_rd;
  logic [CW-1:0]  r_cnt;
  logic [SW-1:0]  r_set;
  logic [N-1:0]   r_j;
  logic [N-1:0]   r_k;
  logic [N-1:0]   r_q;
  logic           r_chk;
  logic           r_mis;
  logic           r_err;
  logic [7:0]     r_ecnt;

  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic [N-1:0]   w_head;
  logic [N-1:0]   w_diff;
  logic [N-1:0]   w_j;
  logic [N-1:0]   w_k;
  logic           w_mis;

  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_push  = target_valid && !w_full;
  assign w_pop   = (r_state == S_IDLE) && !w_empty;
  assign w_head  = r_mem[r_rd];
  assign w_diff  = r_q ^ w_head;
  assign w_mis   = (q_fb != r_q);

  // Only bits that must change get excitation; the rest hold with 00.
  generate
    if (TOGGLE_EN != 0) begin : g_tog
      assign w_j = w_diff;
      assign w_k = w_diff;
    end else begin : g_sr
      assign w_j = w_diff & w_head;
      assign w_k = w_diff & ~w_head;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= target;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      if (w_push && !w_pop)
        r_cnt <= r_cnt + CW'(1);
      else if (!w_push && w_pop)
        r_cnt <= r_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_set   <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_q     <= '0;
      r_chk   <= 1'b0;
      r_mis   <= 1'b0;
      r_err   <= 1'b0;
      r_ecnt  <= '0;
    end else begin
      r_chk <= 1'b0;
      r_mis <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_j     <= w_j;
            r_k     <= w_k;
            r_q     <= w_head;
            r_state <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          r_j     <= '0;
          r_k     <= '0;
          r_set   <= SW'(SETTLE_CYC - 1);
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_set == '0) begin
            r_state <= S_CHECK;
            r_chk   <= 1'b1;
            r_mis   <= w_mis;
            if (w_mis) begin
              r_err <= 1'b1;
              if (r_ecnt != 8'hFF) r_ecnt <= r_ecnt + 8'd1;
            end
          end else begin
            r_set <= r_set - SW'(1);
          end
        end
        S_CHECK: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign target_ready = !w_full;
  assign j            = r_j;
  assign k            = r_k;
  assign q_model      = r_q;
  assign check_pulse  = r_chk;
  assign mismatch     = r_mis;
  assign err          = r_err;
  assign err_count    = r_ecnt;
  assign busy         = (r_state != S_IDLE) || !w_empty;

endmodule
